// File: rtl/tc_meas_pkg.sv
// Shared types and constants for the frequency-measurement sequencer.
// The gate-length helper maps a programmed length of 0 to the full 2^width window.
package tc_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_SEND,
    ST_DONE
  } tc_meas_state_e;

  localparam int ARM_CYCLES  = 3;
  localparam int HDR_OVF_BIT = 7;
  localparam int BYTE_W      = 8;

  function automatic logic [31:0] gate_cycles(input logic [31:0] len, input int width);
    if (len == 32'd0) begin
      return 32'd1 << width;
    end
    return len;
  endfunction

endpackage

// File: rtl/tc_freq_sweep_if.sv
// Byte-record stream port: the producer drives byte/valid, the consumer drives ready.
interface tc_freq_sweep_if;

  logic [tc_meas_pkg::BYTE_W-1:0] out_byte;
  logic                           out_valid;
  logic                           out_ready;

  modport master (output out_byte, output out_valid, input out_ready);
  modport slave  (input out_byte, input out_valid, output out_ready);

endinterface

// File: rtl/tc_edge_sync.sv
// Two-flop synchronizer for an asynchronous oscillator plus a rising-edge detector.
// The pulse is high for one clk cycle per synchronized rising edge.
module tc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/tc_freq_sweep.sv
// Multi-channel frequency-measurement sequencer: counts synchronized edges of one
// oscillator over a gate window and streams {hdr, count MSB..LSB} byte records.
module tc_freq_sweep
  import tc_meas_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [N_CH-1:0]         osc_in,
  input  logic                    start,
  input  logic                    sweep,
  input  logic [$clog2(N_CH)-1:0] ch_sel,
  input  logic [GATE_W-1:0]       gate_len,
  tc_freq_sweep_if.master         out_if,
  output logic                    busy,
  output logic                    done
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int N_BYTES = 1 + CNT_W / 8;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int GCNT_W  = GATE_W + 1;

  tc_meas_state_e state_q, state_d;
  logic              sweep_q, sweep_d;
  logic [CH_W-1:0]   channel_q, channel_d;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [1:0]        arm_cnt_q, arm_cnt_d;
  logic [GCNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic             osc_sel;
  logic             edge_pulse;
  logic             sync_rst;
  logic [IDX_W-1:0] next_idx;
  logic [CNT_W-1:0] cnt_shifted;

  // Abort via ena also flushes the synchronizer so a fresh run starts clean.
  assign sync_rst = rst | ~ena;
  assign osc_sel  = osc_in[channel_q];

  tc_edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (sync_rst),
    .din   (osc_sel),
    .pulse (edge_pulse)
  );

  assign next_idx    = byte_idx_q + IDX_W'(1);
  assign cnt_shifted = cnt_q >> (8 * (N_BYTES - 1 - int'(next_idx)));

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    channel_d   = channel_q;
    gate_len_d  = gate_len_q;
    arm_cnt_d   = arm_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    byte_idx_d  = byte_idx_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sweep_d    = sweep;
          channel_d  = ch_sel;
          gate_len_d = gate_len;
          arm_cnt_d  = '0;
          state_d    = ST_ARM;
        end
      end

      ST_ARM: begin
        cnt_d     = '0;
        ovf_d     = 1'b0;
        arm_cnt_d = arm_cnt_q + 2'd1;
        if (arm_cnt_q == 2'(ARM_CYCLES - 1)) begin
          gate_cnt_d = GCNT_W'(gate_cycles(32'(gate_len_q), GATE_W));
          state_d    = ST_GATE;
        end
      end

      ST_GATE: begin
        if (edge_pulse) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        gate_cnt_d = gate_cnt_q - GCNT_W'(1);
        // The header is built from ovf_d so an overflow on the final gate cycle is reported.
        if (gate_cnt_q == GCNT_W'(1)) begin
          out_byte_d              = 8'(channel_q);
          out_byte_d[HDR_OVF_BIT] = ovf_d;
          out_valid_d             = 1'b1;
          byte_idx_d              = '0;
          state_d                 = ST_SEND;
        end
      end

      ST_SEND: begin
        if (out_valid_q && out_if.out_ready) begin
          if (byte_idx_q == IDX_W'(N_BYTES - 1)) begin
            out_valid_d = 1'b0;
            if (sweep_q && (channel_q < CH_W'(N_CH - 1))) begin
              channel_d = channel_q + CH_W'(1);
              arm_cnt_d = '0;
              state_d   = ST_ARM;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            byte_idx_d = next_idx;
            out_byte_d = cnt_shifted[7:0];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_q     <= ST_IDLE;
      sweep_q     <= 1'b0;
      channel_q   <= '0;
      gate_len_q  <= '0;
      arm_cnt_q   <= '0;
      gate_cnt_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      byte_idx_q  <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      channel_q   <= channel_d;
      gate_len_q  <= gate_len_d;
      arm_cnt_q   <= arm_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      byte_idx_q  <= byte_idx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_if.out_byte  = out_byte_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
